mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch port and its load/store port.
- Sits between the core and memory, and uses the same request / we_re / mask signalling as the instruction memory interface.
- Serialises transactions and uses round-robin arbitration on ties.
- Forwards read data back to the requester and generates a core stall.
- Includes a watchdog that aborts a transaction when memory never responds.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and load/store ports of a core.
// Round-robin on ties, combinational completion forwarding, and a response watchdog.
module mem_port_arbiter #(
    parameter int ADDRESS        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDRESS-1:0]    if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  ls_req,
    input  logic                  ls_we_re,
    input  logic [3:0]            ls_mask,
    input  logic [ADDRESS-1:0]    ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_valid,
    output logic                  if_err,
    output logic                  ls_err,
    output logic                  mem_request,
    output logic                  mem_we_re,
    output logic [3:0]            mem_mask,
    output logic [ADDRESS-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  core_stall
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_ls_q, last_ls_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mem_request_q, mem_request_d;
    logic                  mem_we_re_q, mem_we_re_d;
    logic [3:0]            mem_mask_q, mem_mask_d;
    logic [ADDRESS-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic busy;
    logic timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_ls_q     <= 1'b0;
            cnt_q         <= '0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_ls_q     <= last_ls_d;
            cnt_q         <= cnt_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // A response arriving on the last watchdog cycle wins over the abort.
    assign busy    = (state_q != IDLE);
    assign timeout = busy & ~mem_valid & (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        last_ls_d     = last_ls_q;
        cnt_d         = cnt_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (ls_req && (!if_req || !last_ls_q)) begin
                    state_d       = BUSY_LS;
                    last_ls_d     = 1'b1;
                    cnt_d         = '0;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = ls_we_re;
                    mem_mask_d    = ls_mask;
                    mem_addr_d    = ls_addr;
                    mem_wdata_d   = ls_wdata;
                end else if (if_req) begin
                    state_d       = BUSY_IF;
                    last_ls_d     = 1'b0;
                    cnt_d         = '0;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = 1'b0;
                    mem_mask_d    = 4'b1111;
                    mem_addr_d    = if_addr;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_valid || timeout) begin
                    state_d       = IDLE;
                    mem_request_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_valid    = mem_valid & (state_q == BUSY_IF);
    assign ls_valid    = mem_valid & (state_q == BUSY_LS);
    assign if_err      = timeout & (state_q == BUSY_IF);
    assign ls_err      = timeout & (state_q == BUSY_LS);
    assign if_rdata    = if_valid ? mem_rdata : '0;
    assign ls_rdata    = ls_valid ? mem_rdata : '0;
    assign core_stall  = (if_req & ~if_valid) | (ls_req & ~ls_valid);

    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_mask    = mem_mask_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie round-robin, store, timeout,
// mid-transaction reset and spurious responses, all with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ls_req;
    logic        ls_we_re;
    logic [3:0]  ls_mask;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_valid;
    logic        if_err;
    logic        ls_err;
    logic        mem_request;
    logic        mem_we_re;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        core_stall;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDRESS(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we_re(ls_we_re), .ls_mask(ls_mask), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
        .if_err(if_err), .ls_err(ls_err),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .core_stall(core_stall)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we_re  = 1'b0;
        ls_mask   = '0;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        do_reset();
        #1;
        check_val("rst_mem_request", 32'(mem_request), 32'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_mem_mask", 32'(mem_mask), 32'h0);
        check_val("rst_valids", 32'({if_valid, ls_valid, if_err, ls_err}), 32'h0);
        check_val("rst_stall", 32'(core_stall), 32'h0);

        // Single fetch, memory answers two cycles after mem_request rises
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        check_val("fetch_stall_pre", 32'(core_stall), 32'h1);
        check_val("fetch_req_latency", 32'(mem_request), 32'h0);
        @(negedge clk); #1;
        check_val("fetch_mem_request", 32'(mem_request), 32'h1);
        check_val("fetch_we_re", 32'(mem_we_re), 32'h0);
        check_val("fetch_mask", 32'(mem_mask), 32'hF);
        check_val("fetch_addr", mem_addr, 32'h10);
        check_val("fetch_no_early_valid", 32'(if_valid), 32'h0);
        @(negedge clk); #1;
        check_val("fetch_held", 32'(mem_request), 32'h1);
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'h0000_0093;
        #1;
        check_val("fetch_if_valid", 32'(if_valid), 32'h1);
        check_val("fetch_if_rdata", if_rdata, 32'h93);
        check_val("fetch_no_ls_valid", 32'(ls_valid), 32'h0);
        check_val("fetch_ls_rdata_gated", ls_rdata, 32'h0);
        check_val("fetch_stall_done", 32'(core_stall), 32'h0);
        @(negedge clk);
        mem_valid = 1'b0; if_req = 1'b0;
        #1;
        check_val("fetch_back_idle", 32'(mem_request), 32'h0);
        check_val("fetch_if_valid_once", 32'(if_valid), 32'h0);
        check_val("fetch_if_rdata_gated", if_rdata, 32'h0);
        $display("txn fetch addr=%h rdata=%h", 32'h10, 32'h93);

        // Tie round-robin from reset: LS, IF, LS, IF
        do_reset();
        @(negedge clk);
        ls_addr = 32'h200; if_addr = 32'h40; ls_we_re = 1'b0; ls_mask = 4'hF;
        if_req = 1'b1; ls_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic        is_ls;
            logic [31:0] data;
            is_ls = (i % 2 == 0);
            data  = 32'hA000 + 32'(i);
            @(negedge clk); #1;
            check_val($sformatf("tie%0d_addr", i), mem_addr, is_ls ? 32'h200 : 32'h40);
            check_val($sformatf("tie%0d_req", i), 32'(mem_request), 32'h1);
            mem_valid = 1'b1; mem_rdata = data;
            #1;
            check_val($sformatf("tie%0d_if_valid", i), 32'(if_valid), 32'(!is_ls));
            check_val($sformatf("tie%0d_ls_valid", i), 32'(ls_valid), 32'(is_ls));
            check_val($sformatf("tie%0d_if_rdata", i), if_rdata, is_ls ? 32'h0 : data);
            check_val($sformatf("tie%0d_ls_rdata", i), ls_rdata, is_ls ? data : 32'h0);
            @(negedge clk);
            mem_valid = 1'b0;
            #1;
            check_val($sformatf("tie%0d_idle", i), 32'(mem_request), 32'h0);
            $display("txn tie %0d owner=%s data=%h", i, is_ls ? "ls" : "if", data);
        end
        if_req = 1'b0; ls_req = 1'b0;

        // Store
        @(negedge clk);
        ls_req = 1'b1; ls_we_re = 1'b1; ls_mask = 4'b0011;
        ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("st_stall_pre", 32'(core_stall), 32'h1);
        @(negedge clk); #1;
        check_val("st_req", 32'(mem_request), 32'h1);
        check_val("st_we_re", 32'(mem_we_re), 32'h1);
        check_val("st_mask", 32'(mem_mask), 32'h3);
        check_val("st_addr", mem_addr, 32'h100);
        check_val("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_val("st_stall_busy", 32'(core_stall), 32'h1);
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        check_val("st_ls_valid", 32'(ls_valid), 32'h1);
        check_val("st_if_valid", 32'(if_valid), 32'h0);
        check_val("st_stall_done", 32'(core_stall), 32'h0);
        @(negedge clk);
        mem_valid = 1'b0; ls_req = 1'b0; ls_we_re = 1'b0;
        #1;
        check_val("st_idle", 32'(mem_request), 32'h0);
        check_val("st_stall_after", 32'(core_stall), 32'h0);
        $display("txn store addr=%h wdata=%h mask=%h", 32'h100, 32'hDEAD_BEEF, 4'h3);

        // Watchdog abort with TIMEOUT_CYCLES = 4
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            check_val($sformatf("to_busy%0d_err", c), 32'(if_err), 32'h0);
            check_val($sformatf("to_busy%0d_req", c), 32'(mem_request), 32'h1);
        end
        @(negedge clk);
        ls_req = 1'b1; ls_addr = 32'h300; ls_mask = 4'hF; ls_we_re = 1'b0;
        #1;
        check_val("to_if_err", 32'(if_err), 32'h1);
        check_val("to_ls_err", 32'(ls_err), 32'h0);
        check_val("to_if_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check_val("to_req_dropped", 32'(mem_request), 32'h0);
        check_val("to_err_once", 32'(if_err), 32'h0);
        @(negedge clk); #1;
        check_val("to_ls_granted", 32'(mem_request), 32'h1);
        check_val("to_ls_addr", mem_addr, 32'h300);
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'h77;
        #1;
        check_val("to_ls_valid", 32'(ls_valid), 32'h1);
        check_val("to_ls_rdata", ls_rdata, 32'h77);
        @(negedge clk);
        mem_valid = 1'b0; ls_req = 1'b0;
        $display("txn timeout fetch addr=%h then load addr=%h", 32'h80, 32'h300);

        // Reset in the middle of a load/store transaction
        @(negedge clk);
        ls_req = 1'b1; ls_we_re = 1'b1; ls_mask = 4'h5;
        ls_addr = 32'h400; ls_wdata = 32'h1234;
        @(negedge clk); #1;
        check_val("mr_busy_req", 32'(mem_request), 32'h1);
        #1;
        rst = 1'b0; mem_valid = 1'b1;
        #1;
        check_val("mr_async_req", 32'(mem_request), 32'h0);
        check_val("mr_async_addr", mem_addr, 32'h0);
        check_val("mr_async_wdata", mem_wdata, 32'h0);
        check_val("mr_async_cmd", 32'({mem_we_re, mem_mask}), 32'h0);
        check_val("mr_async_pulses", 32'({if_valid, ls_valid, if_err, ls_err}), 32'h0);
        ls_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mr_stray_ls_valid", 32'(ls_valid), 32'h0);
        check_val("mr_stray_if_valid", 32'(if_valid), 32'h0);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check_val("mr_stray_no_req", 32'(mem_request), 32'h0);
        ls_addr = 32'h500; if_addr = 32'h600; ls_we_re = 1'b0;
        ls_req = 1'b1; if_req = 1'b1;
        @(negedge clk); #1;
        check_val("mr_tie_req", 32'(mem_request), 32'h1);
        check_val("mr_tie_addr", mem_addr, 32'h500);
        mem_valid = 1'b1; mem_rdata = 32'hCAFE;
        #1;
        check_val("mr_tie_ls_valid", 32'(ls_valid), 32'h1);
        @(negedge clk);
        mem_valid = 1'b0; ls_req = 1'b0; if_req = 1'b0;
        $display("txn reset mid-op, next tie addr=%h", 32'h500);

        // Spurious response while idle
        @(negedge clk);
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val($sformatf("sp%0d_pulses", k), 32'({if_valid, ls_valid, if_err, ls_err}), 32'h0);
            check_val($sformatf("sp%0d_req", k), 32'(mem_request), 32'h0);
            check_val($sformatf("sp%0d_rdata", k), if_rdata | ls_rdata, 32'h0);
            @(negedge clk);
        end
        mem_valid = 1'b0;
        $display("txn spurious response ignored");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
